// File: rtl/dma_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_ctrl_if
//  Description : Command, memory-master and PIM bundle for dma_ctrl.
//                The master modport is the DMA engine's view; the slave
//                modport is the view of the surrounding system.
//                o_dma_err exists only when DMA_ERR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface dma_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int PIM_AW = 11
);
    // Command
    logic              i_dma_en;
    logic [2:0]        i_dma_funct3;
    logic [3:0]        i_dma_sel_pim;
    logic [12:0]       i_dma_size;
    logic [XLEN-1:0]   i_dma_mem_addr;
    logic              o_dma_busy;
`ifdef DMA_ERR_EN
    logic              o_dma_err;
`endif
    // Memory master
    logic              o_mem_req;
    logic              i_mem_gnt;
    logic [XLEN-1:0]   o_mem_addr;
    logic [XLEN-1:0]   o_mem_wr_data;
    logic [XLEN-1:0]   i_mem_rd_data;
    logic              o_mem_read;
    logic              o_mem_write;
    logic [3:0]        o_mem_size;
    // PIM
    logic [3:0]        o_pim_sel;
    logic [PIM_AW-1:0] o_pim_addr;
    logic              o_pim_wr_en;
    logic [XLEN-1:0]   o_pim_wr_data;
    logic              o_pim_rd_en;
    logic [XLEN-1:0]   i_pim_rd_data;

    modport master (
        input  i_dma_en, i_dma_funct3, i_dma_sel_pim, i_dma_size, i_dma_mem_addr,
        output o_dma_busy,
`ifdef DMA_ERR_EN
        output o_dma_err,
`endif
        output o_mem_req, o_mem_addr, o_mem_wr_data, o_mem_read, o_mem_write, o_mem_size,
        input  i_mem_gnt, i_mem_rd_data,
        output o_pim_sel, o_pim_addr, o_pim_wr_en, o_pim_wr_data, o_pim_rd_en,
        input  i_pim_rd_data
    );

    modport slave (
        output i_dma_en, i_dma_funct3, i_dma_sel_pim, i_dma_size, i_dma_mem_addr,
        input  o_dma_busy,
`ifdef DMA_ERR_EN
        input  o_dma_err,
`endif
        input  o_mem_req, o_mem_addr, o_mem_wr_data, o_mem_read, o_mem_write, o_mem_size,
        output i_mem_gnt, i_mem_rd_data,
        input  o_pim_sel, o_pim_addr, o_pim_wr_en, o_pim_wr_data, o_pim_rd_en,
        output i_pim_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dma_ctrl
//  Description : Word-wise DMA between system memory and a PIM bank.
//                LOAD (funct3=000) copies memory -> PIM, STORE (001) copies
//                PIM -> memory, one 32-bit word per RD -> CAP -> WR pass.
//                Optional macro DMA_ERR_EN adds a sticky o_dma_err flag for
//                illegal funct3 / misaligned address commands.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_ctrl #(
    parameter int XLEN   = 32,
    parameter int PIM_AW = 11
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst_n,
    dma_ctrl_if.master bus
);
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD   = 3'd1;
    localparam logic [2:0] c_ST_CAP  = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [2:0] c_F3_LOAD  = 3'b000;
    localparam logic [2:0] c_F3_STORE = 3'b001;
    localparam logic [3:0] c_ALL_BYTES = 4'b1111;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_store;
    logic [3:0]        r_sel;
    logic [10:0]       r_nwords;
    logic [10:0]       r_k;
    logic [XLEN-1:0]   r_base;
    logic [XLEN-1:0]   r_data;
    logic              r_busy;

    logic              w_accept;
    logic              w_cmd_legal;
    logic              w_cmd_empty;
    logic [10:0]       w_cmd_words;
    logic              w_last;
    logic [XLEN-1:0]   w_addr_k;
    logic [PIM_AW-1:0] w_idx_k;

    logic              w_mem_req;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [XLEN-1:0]   w_mem_addr;
    logic [XLEN-1:0]   w_mem_wr_data;
    logic [PIM_AW-1:0] w_pim_addr;
    logic              w_pim_wr_en;
    logic [XLEN-1:0]   w_pim_wr_data;
    logic              w_pim_rd_en;

    // Size bits [1:0] never matter; address bits [1:0] only feed the error check.
    logic              w_unused;
    assign w_unused = &{1'b0, bus.i_dma_size[1:0], bus.i_dma_mem_addr[1:0]};

    assign w_accept    = (r_state == c_ST_IDLE) && bus.i_dma_en;
    assign w_cmd_legal = (bus.i_dma_funct3 == c_F3_LOAD) || (bus.i_dma_funct3 == c_F3_STORE);
    assign w_cmd_words = bus.i_dma_size[12:2];

`ifdef DMA_ERR_EN
    logic w_cmd_bad;
    logic r_err;
    assign w_cmd_bad   = !w_cmd_legal || (bus.i_dma_mem_addr[1:0] != 2'b00);
    assign w_cmd_empty = w_cmd_bad || (w_cmd_words == 11'd0);

    // Sticky error flag, re-evaluated on every accepted command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_err <= 1'b0;
        else if (w_accept) r_err <= w_cmd_bad;
    end
    assign bus.o_dma_err = r_err;
`else
    // Without error reporting an illegal direction behaves like an empty transfer
    assign w_cmd_empty = !w_cmd_legal || (w_cmd_words == 11'd0);
`endif

    assign w_last   = (r_k == (r_nwords - 11'd1));
    assign w_addr_k = r_base + (XLEN'(r_k) << 2);
    assign w_idx_k  = PIM_AW'(r_k);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= c_ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: memory phases wait for grant, PIM phases take one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next = w_cmd_empty ? c_ST_DONE : c_ST_RD;
            c_ST_RD:   if (r_store || bus.i_mem_gnt) w_next = c_ST_CAP;
            c_ST_CAP:  w_next = c_ST_WR;
            c_ST_WR:   if (!r_store || bus.i_mem_gnt) w_next = w_last ? c_ST_DONE : c_ST_RD;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Command latch, word counter, data capture and registered busy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_store  <= 1'b0;
            r_sel    <= 4'b0000;
            r_nwords <= '0;
            r_k      <= '0;
            r_base   <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_next != c_ST_IDLE);
            if (w_accept) begin
                r_store  <= (bus.i_dma_funct3 == c_F3_STORE);
                r_sel    <= bus.i_dma_sel_pim;
                r_nwords <= w_cmd_words;
                r_base   <= {bus.i_dma_mem_addr[XLEN-1:2], 2'b00};
                r_k      <= '0;
            end
            if (r_state == c_ST_CAP)
                r_data <= r_store ? bus.i_pim_rd_data : bus.i_mem_rd_data;
            if ((r_state == c_ST_WR) && (w_next == c_ST_RD))
                r_k <= r_k + 11'd1;
        end
    end

    // Output decode: only the strobes of the current phase are driven
    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_addr    = '0;
        w_mem_wr_data = '0;
        w_pim_addr    = '0;
        w_pim_wr_en   = 1'b0;
        w_pim_wr_data = '0;
        w_pim_rd_en   = 1'b0;
        case (r_state)
            c_ST_RD: begin
                if (r_store) begin
                    w_pim_rd_en = 1'b1;
                    w_pim_addr  = w_idx_k;
                end else begin
                    w_mem_req  = 1'b1;
                    w_mem_read = 1'b1;
                    w_mem_addr = w_addr_k;
                end
            end
            c_ST_WR: begin
                if (r_store) begin
                    w_mem_req     = 1'b1;
                    w_mem_write   = 1'b1;
                    w_mem_addr    = w_addr_k;
                    w_mem_wr_data = r_data;
                end else begin
                    w_pim_wr_en   = 1'b1;
                    w_pim_addr    = w_idx_k;
                    w_pim_wr_data = r_data;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_dma_busy    = r_busy;
    assign bus.o_mem_req     = w_mem_req;
    assign bus.o_mem_read    = w_mem_read;
    assign bus.o_mem_write   = w_mem_write;
    assign bus.o_mem_addr    = w_mem_addr;
    assign bus.o_mem_wr_data = w_mem_wr_data;
    assign bus.o_mem_size    = w_mem_req ? c_ALL_BYTES : 4'b0000;
    assign bus.o_pim_sel     = (r_state != c_ST_IDLE) ? r_sel : 4'b0000;
    assign bus.o_pim_addr    = w_pim_addr;
    assign bus.o_pim_wr_en   = w_pim_wr_en;
    assign bus.o_pim_wr_data = w_pim_wr_data;
    assign bus.o_pim_rd_en   = w_pim_rd_en;
endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_ctrl
//  Description : Self-checking bench for dma_ctrl. A transaction-level model
//                lists every memory and PIM access a command must produce;
//                a per-cycle compare process matches the DUT against it.
//                Honours DMA_ERR_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_ctrl;
    localparam int XLEN   = 32;
    localparam int PIM_AW = 5;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } mem_t;
    typedef struct { logic wr; logic [PIM_AW-1:0] idx; logic [31:0] data; } pim_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    dma_ctrl_if #(.XLEN(XLEN), .PIM_AW(PIM_AW)) bus ();
    dma_ctrl #(.XLEN(XLEN), .PIM_AW(PIM_AW)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    mem_t              exp_mem[$];
    pim_t              exp_pim[$];
    logic [31:0]       mem_log[$];
    logic [PIM_AW-1:0] pim_log[$];
    logic [3:0]        cur_sel = 4'h0;
    logic              exp_err = 1'b0;
    int                stalls = 0;
    int                gnt_mode = 0;
    int                stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} ^ (a * 32'h9E3779B1);
    endfunction

    function automatic logic [31:0] pimval(input logic [3:0] s, input logic [PIM_AW-1:0] i);
        return (32'(s) << 28) ^ (32'(i) * 32'h0101_0101) ^ 32'h2468_ACE1;
    endfunction

    function automatic logic all_zero();
        logic any;
        any = bus.o_dma_busy | bus.o_mem_req | (|bus.o_mem_addr) | (|bus.o_mem_wr_data)
            | bus.o_mem_read | bus.o_mem_write | (|bus.o_mem_size) | (|bus.o_pim_sel)
            | (|bus.o_pim_addr) | bus.o_pim_wr_en | (|bus.o_pim_wr_data) | bus.o_pim_rd_en;
`ifdef DMA_ERR_EN
        any = any | bus.o_dma_err;
`endif
        return !any;
    endfunction

    // Memory / PIM responders: read data appears only in the cycle after the access
    logic              pend_m = 1'b0, pend_p = 1'b0;
    logic [31:0]       pend_ma = '0;
    logic [PIM_AW-1:0] pend_pi = '0;
    logic [3:0]        pend_ps = '0;
    always @(negedge i_clk) begin
        pend_m  = bus.o_mem_req && bus.i_mem_gnt && bus.o_mem_read;
        pend_ma = bus.o_mem_addr;
        pend_p  = bus.o_pim_rd_en;
        pend_pi = bus.o_pim_addr;
        pend_ps = bus.o_pim_sel;
    end
    always @(posedge i_clk) begin
        #1;
        bus.i_mem_rd_data = pend_m ? memval(pend_ma) : $urandom;
        bus.i_pim_rd_data = pend_p ? pimval(pend_ps, pend_pi) : $urandom;
        if (gnt_mode == 0) bus.i_mem_gnt = 1'b1;
        else if (gnt_mode == 1) bus.i_mem_gnt = ($urandom_range(0, 2) != 0);
        else if (bus.o_mem_req && bus.o_mem_write && stall_left > 0) begin
            bus.i_mem_gnt = 1'b0;
            stall_left--;
        end else bus.i_mem_gnt = 1'b1;
    end

    // Per-cycle compare against the transaction model
    logic        p_req = 1'b0, p_gnt = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge i_clk) begin : compare
        mem_t em;
        pim_t ep;
        if (!i_rst_n) begin
            check("reset_outputs", 64'(all_zero()), 64'd1);
            p_req = 1'b0;
        end else begin
            check("mem_size", bus.o_mem_size, bus.o_mem_req ? 64'hF : 64'h0);
            check("mem_rw_excl", bus.o_mem_read & bus.o_mem_write, 0);
            check("mem_rw_req", bus.o_mem_read | bus.o_mem_write, bus.o_mem_req);
            check("mem_idle", bus.o_mem_req ? 64'd0 : {bus.o_mem_addr, bus.o_mem_wr_data}, 0);
            check("pim_excl", bus.o_pim_wr_en & bus.o_pim_rd_en, 0);
            check("pim_idle", (bus.o_pim_wr_en ? 64'd0 : 64'(bus.o_pim_wr_data))
                  | ((bus.o_pim_wr_en | bus.o_pim_rd_en) ? 64'd0 : 64'(bus.o_pim_addr)), 0);
            check("pim_sel", bus.o_pim_sel, bus.o_dma_busy ? cur_sel : 4'h0);
`ifdef DMA_ERR_EN
            check("dma_err", bus.o_dma_err, exp_err);
`endif
            if (p_req && !p_gnt) begin
                check("stall_ctl", {bus.o_mem_req, bus.o_mem_read, bus.o_mem_write}, {1'b1, p_rd, p_wr});
                check("stall_addr", bus.o_mem_addr, p_addr);
                check("stall_data", bus.o_mem_wr_data, p_wdata);
            end
            if (bus.o_mem_req && !bus.i_mem_gnt) stalls++;
            if (bus.o_mem_req && bus.i_mem_gnt) begin
                check("mem_expected", 64'(exp_mem.size() > 0), 1);
                if (exp_mem.size() > 0) begin
                    em = exp_mem.pop_front();
                    check("mem_dir", bus.o_mem_write, em.wr);
                    check("mem_addr", bus.o_mem_addr, em.addr);
                    check("mem_wdata", bus.o_mem_wr_data, em.data);
                end
                mem_log.push_back(bus.o_mem_addr);
            end
            if (bus.o_pim_wr_en || bus.o_pim_rd_en) begin
                check("pim_expected", 64'(exp_pim.size() > 0), 1);
                if (exp_pim.size() > 0) begin
                    ep = exp_pim.pop_front();
                    check("pim_dir", bus.o_pim_wr_en, ep.wr);
                    check("pim_addr", bus.o_pim_addr, ep.idx);
                    check("pim_wdata", bus.o_pim_wr_data, ep.data);
                end
                pim_log.push_back(bus.o_pim_addr);
            end
            p_req = bus.o_mem_req; p_gnt = bus.i_mem_gnt;
            p_rd = bus.o_mem_read; p_wr = bus.o_mem_write;
            p_addr = bus.o_mem_addr; p_wdata = bus.o_mem_wr_data;
        end
    end

    // Model: number of words and the exact access lists for one command
    task automatic plan(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                        input logic [31:0] addr, output int nw, output logic bad);
        logic legal;
        logic [31:0] a;
        logic [PIM_AW-1:0] idx;
        legal = (f3 == 3'b000) || (f3 == 3'b001);
`ifdef DMA_ERR_EN
        bad = !legal || (addr[1:0] != 2'b00);
`else
        bad = !legal;
`endif
        nw = bad ? 0 : int'(size[12:2]);
        for (int k = 0; k < nw; k++) begin
            a   = {addr[31:2], 2'b00} + 32'(4 * k);
            idx = PIM_AW'(k % (1 << PIM_AW));
            if (f3 == 3'b000) begin
                exp_mem.push_back('{1'b0, a, 32'h0});
                exp_pim.push_back('{1'b1, idx, memval(a)});
            end else begin
                exp_pim.push_back('{1'b0, idx, 32'h0});
                exp_mem.push_back('{1'b1, a, pimval(sel, idx)});
            end
        end
    endtask

    task automatic pulse(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                         input logic [31:0] addr, input logic bad);
        @(posedge i_clk); #2;
        bus.i_dma_en = 1'b1; bus.i_dma_funct3 = f3; bus.i_dma_sel_pim = sel;
        bus.i_dma_size = size; bus.i_dma_mem_addr = addr;
        @(negedge i_clk);
        check("busy_accept", bus.o_dma_busy, 0);
        @(posedge i_clk);
        cur_sel = sel;
        exp_err = bad;
        #2;
        bus.i_dma_en = 1'b0; bus.i_dma_funct3 = 3'($urandom); bus.i_dma_sel_pim = 4'($urandom);
        bus.i_dma_size = 13'($urandom); bus.i_dma_mem_addr = $urandom;
    endtask

    task automatic run_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                           input logic [31:0] addr, input bit dup_req, output int busy_n);
        int nw;
        logic bad;
        bit dup;
        plan(f3, sel, size, addr, nw, bad);
        dup = dup_req && (nw >= 2);
        stalls = 0;
        mem_log.delete();
        pim_log.delete();
        pulse(f3, sel, size, addr, bad);
        busy_n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge i_clk);
            if (i == 0) check("busy_rise", bus.o_dma_busy, 1);
            if (!bus.o_dma_busy) break;
            busy_n++;
            if (dup) begin
                bus.i_dma_en = (i == 2);
                if (i == 2) begin
                    bus.i_dma_funct3 = 3'($urandom_range(0, 1)); bus.i_dma_size = 13'($urandom);
                    bus.i_dma_mem_addr = $urandom; bus.i_dma_sel_pim = 4'($urandom);
                end
            end
        end
        bus.i_dma_en = 1'b0;
        // RD, CAP, WR per word plus DONE, stretched by every refused grant
        check("busy_len", busy_n, 3 * nw + 1 + stalls);
        check("mem_missing", exp_mem.size(), 0);
        check("pim_missing", exp_pim.size(), 0);
    endtask

    task automatic reset_mid();
        int nw;
        logic bad;
        bit found;
        gnt_mode = 0;
        plan(3'b000, 4'h5, 13'd32, 32'h3000_0040, nw, bad);
        pulse(3'b000, 4'h5, 13'd32, 32'h3000_0040, bad);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (bus.o_pim_wr_en && bus.o_pim_addr == 2) begin found = 1'b1; break; end
        end
        check("reset_reach_wr2", 64'(found), 1);
        #1;
        i_rst_n = 1'b0;
        exp_mem.delete(); exp_pim.delete();
        exp_err = 1'b0; cur_sel = 4'h0;
        #1;
        check("reset_async", 64'(all_zero()), 1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check("post_reset_busy", bus.o_dma_busy, 0);
    endtask

    int bn;
    initial begin
        bus.i_dma_en = 1'b0; bus.i_dma_funct3 = '0; bus.i_dma_sel_pim = '0;
        bus.i_dma_size = '0; bus.i_dma_mem_addr = '0; bus.i_mem_gnt = 1'b0;
        bus.i_mem_rd_data = '0; bus.i_pim_rd_data = '0;
        i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_state", 64'(all_zero()), 1);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // LOAD 4 words, grant always: 4 x (RD,CAP,WR) + DONE = 13 busy cycles
        gnt_mode = 0;
        run_cmd(3'b000, 4'h2, 13'd16, 32'h2000_0100, 0, bn);
        check("load16_busy", bn, 13);
        check("load16_nmem", mem_log.size(), 4);
        check("load16_a0", mem_log[0], 32'h2000_0100);
        check("load16_a3", mem_log[3], 32'h2000_010C);
        check("load16_idx3", pim_log[3], 3);

        // STORE 2 words with three refused grants on the first write
        gnt_mode = 2; stall_left = 3;
        run_cmd(3'b001, 4'hA, 13'd8, 32'h2000_0000, 0, bn);
        check("store8_busy", bn, 10);
        check("store8_stalls", stalls, 3);
        check("store8_nmem", mem_log.size(), 2);
        check("store8_a1", mem_log[1], 32'h2000_0004);

        // Word count zero
        gnt_mode = 0;
        run_cmd(3'b000, 4'h1, 13'd3, 32'h1000_0000, 0, bn);
        check("size3_busy", bn, 1);
        check("size3_naccess", mem_log.size() + pim_log.size(), 0);

        // Memory address wraps past the top of the address space
        run_cmd(3'b000, 4'h3, 13'd16, 32'hFFFF_FFF8, 0, bn);
        check("wrap_a2", mem_log[2], 32'h0000_0000);

        // PIM word index wraps modulo 2^PIM_AW
        run_cmd(3'b001, 4'h9, 13'd160, 32'h0400_0000, 0, bn);
        check("pimwrap_n", pim_log.size(), 40);
        check("pimwrap_idx33", pim_log[33], 1);

        // Second command pulse while busy is ignored
        run_cmd(3'b000, 4'h6, 13'd24, 32'h0000_0800, 1, bn);
        check("dup_busy", bn, 19);

`ifdef DMA_ERR_EN
        run_cmd(3'b111, 4'h4, 13'd64, 32'h0000_1000, 0, bn);
        check("err_busy", bn, 1);
        check("err_flag", bus.o_dma_err, 1);
        run_cmd(3'b000, 4'h4, 13'd8, 32'h0000_1000, 0, bn);
        check("err_clear", bus.o_dma_err, 0);
`else
        run_cmd(3'b001, 4'h7, 13'd8, 32'h0000_0103, 0, bn);
        check("misalign_a0", mem_log[0], 32'h0000_0100);
        run_cmd(3'b101, 4'h7, 13'd64, 32'h0000_0200, 0, bn);
        check("illegal_busy", bn, 1);
`endif

        // Reset in the middle of word 2 of an 8-word transfer
        reset_mid();

        // Randomized traffic with random grant behaviour
        gnt_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            run_cmd(f3, 4'($urandom), 13'($urandom_range(0, 256)), a, $urandom_range(0, 3) == 0, bn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
